fp_minmax_pipe: RTL

Parametrised, pipelined IEEE-754 min/max unit for the FP_Unit, the successor to the combinational min/max selector. Generic exponent/mantissa widths (binary32/binary64/other) with RISC-V fmin/fmax semantics: -0 < +0, NaN-aware selection, canonical NaN and invalid flag. Two-stage pipeline with valid/ready handshake, so it sits on the FP execute path with backpressure.

---
 rtl/fp_minmax_pkg.sv | 31 +++
 rtl/fp_minmax_pipe_classify.sv | 23 ++
 rtl/fp_minmax_pipe.sv | 105 ++++++++++
 3 files changed

// File: rtl/fp_minmax_pkg.sv
// Shared constants and helpers for the pipelined IEEE-754 min/max unit.
package fp_minmax_pkg;

  localparam int B32_EXP_W = 8;
  localparam int B32_MAN_W = 23;
  localparam int B64_EXP_W = 11;
  localparam int B64_MAN_W = 52;

  // Helpers work on a wide container so any EXP_W/MAN_W up to 128 bits fits.
  localparam int KEY_W = 128;

  function automatic logic [KEY_W-1:0] canonical_nan(input int exp_w, input int man_w);
    logic [KEY_W-1:0] one;
    one = KEY_W'(1);
    return (((one << exp_w) - one) << man_w) | (one << (man_w - 1));
  endfunction

  // Maps a w-bit float onto an unsigned key whose order matches the numeric
  // order, with -0 below +0; negative values are bit-inverted.
  function automatic logic [KEY_W-1:0] ordering_key(input logic [KEY_W-1:0] x, input int w);
    logic [KEY_W-1:0] one;
    logic [KEY_W-1:0] mask;
    logic [KEY_W-1:0] msb;
    one  = KEY_W'(1);
    mask = (one << w) - one;
    msb  = one << (w - 1);
    if ((x & msb) != '0) return ~x & mask;
    return x ^ msb;
  endfunction

endpackage

// File: rtl/fp_minmax_pipe_classify.sv
// Combinational field classifier for one operand; the sign bit is not needed.
module fp_classify #(
  parameter int EXP_W = 11,
  parameter int MAN_W = 52
) (
  input  logic [EXP_W+MAN_W-1:0] mag,
  output logic                   is_nan,
  output logic                   is_snan,
  output logic                   is_zero,
  output logic                   is_inf
);

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man_f;

  assign exp_f   = mag[EXP_W+MAN_W-1:MAN_W];
  assign man_f   = mag[MAN_W-1:0];
  assign is_nan  = (&exp_f) & (|man_f);
  assign is_snan = is_nan & ~man_f[MAN_W-1];
  assign is_zero = ~(|exp_f) & ~(|man_f);
  assign is_inf  = (&exp_f) & ~(|man_f);

endmodule

// File: rtl/fp_minmax_pipe.sv
// Two-stage IEEE-754 min/max with RISC-V fmin/fmax NaN rules and canonical NaN.
module fp_minmax_pipe
  import fp_minmax_pkg::*;
#(
  parameter int EXP_W = B64_EXP_W,
  parameter int MAN_W = B64_MAN_W,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         in_clk,
  input  logic         in_rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_numA,
  input  logic [W-1:0] in_numB,
  input  logic         in_ctrl_minmax,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_nv
);

  localparam logic [W-1:0] CNAN = W'(canonical_nan(EXP_W, MAN_W));

  // Handshake: a transfer happens on a rising edge where valid & ready; a
  // stage advances when it is empty or its downstream stage advances.
  logic s1_adv, s2_adv;
  logic s1_valid, s2_valid;

  logic [W-1:0] s1_a, s1_b;
  logic         s1_max, s1_a_nan, s1_b_nan, s1_nv, s1_a_lt_b;
  logic [W-1:0] s2_data;
  logic         s2_nv;

  logic a_nan, a_snan, a_zero, a_inf;
  logic b_nan, b_snan, b_zero, b_inf;
  logic [KEY_W-1:0] key_a, key_b;
  logic [W-1:0] sel;

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
    .mag(in_numA[W-2:0]), .is_nan(a_nan), .is_snan(a_snan), .is_zero(a_zero), .is_inf(a_inf)
  );
  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
    .mag(in_numB[W-2:0]), .is_nan(b_nan), .is_snan(b_snan), .is_zero(b_zero), .is_inf(b_inf)
  );

  assign key_a = ordering_key(KEY_W'(in_numA), W);
  assign key_b = ordering_key(KEY_W'(in_numB), W);

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;
  assign out_data  = s2_data;
  assign out_nv    = s2_nv;

  // Equal keys mean identical encodings, so either operand is the A result.
  always_comb begin
    sel = s1_a;
    if (s1_a_nan && s1_b_nan) sel = CNAN;
    else if (s1_a_nan)        sel = s1_b;
    else if (s1_b_nan)        sel = s1_a;
    else if (s1_max)          sel = s1_a_lt_b ? s1_b : s1_a;
    else                      sel = s1_a_lt_b ? s1_a : s1_b;
  end

  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_max    <= 1'b0;
      s1_a_nan  <= 1'b0;
      s1_b_nan  <= 1'b0;
      s1_nv     <= 1'b0;
      s1_a_lt_b <= 1'b0;
      s2_valid  <= 1'b0;
      s2_data   <= '0;
      s2_nv     <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_a      <= in_numA;
          s1_b      <= in_numB;
          s1_max    <= in_ctrl_minmax;
          s1_a_nan  <= a_nan;
          s1_b_nan  <= b_nan;
          s1_nv     <= a_snan | b_snan;
          s1_a_lt_b <= key_a < key_b;
        end
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data <= sel;
          s2_nv   <= s1_nv;
        end
      end
      // Classes are mutually exclusive; a violation means a broken classifier.
      if (in_valid)
        assert (!(a_inf && (a_nan || a_zero)) && !(b_inf && (b_nan || b_zero)));
    end
  end

endmodule
